// File: rtl/alu_instr_sequencer.sv
// ============================================================================
// Module   : alu_instr_sequencer
// Purpose  : FIFO-buffered issue/writeback sequencer for a 4x32 regfile + ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_instr_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [8:0]       instr_in,
    output logic             instr_ready,
    output logic [1:0]       addr1,
    output logic [1:0]       addr2,
    output logic [1:0]       addr3,
    input  logic [31:0]      data1,
    input  logic [31:0]      data2,
    output logic [31:0]      data3,
    output logic             wr,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [2:0]       alucontrol,
    input  logic [31:0]      result,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [8:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [FCNT_W-1:0] count;
    logic [8:0]        ir;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              ir_halt;

    assign fifo_empty  = (count == '0);
    assign instr_ready = (count != FCNT_W'(FIFO_DEPTH));
    assign push        = instr_valid && instr_ready;
    assign ir_halt     = (ir[8:6] == OP_HALT);

    // Read/ALU controls decode straight from IR so they are glitch-free registers.
    assign addr1      = ir[3:2];
    assign addr2      = ir[1:0];
    assign alucontrol = ir[8:6];
    assign wr         = (state == WB) && !ir_halt;
    assign done       = (state == WB);
    assign busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !halted) begin
                    pop       = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: state_nxt = ir_halt ? WB : EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                // A retiring HALT must not let the next entry issue.
                if (!fifo_empty && !ir_halt && !halted) begin
                    pop       = 1'b1;
                    state_nxt = READ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            data3   <= '0;
            addr3   <= '0;
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
                ir   <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + FCNT_W'(1);
                2'b01:   count <= count - FCNT_W'(1);
                default: count <= count;
            endcase
            if (state == READ) begin
                a <= data1;
                b <= data2;
            end
            if (state == EXEC) begin
                data3 <= result;
                addr3 <= ir[5:4];
            end
            if (state == WB) begin
                retired <= retired + CNT_W'(1);
                if (ir_halt) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
